// File: rtl/arith_fptosi_arbiter.sv
// Round-robin front end that shares one float-to-signed-int converter between NUM_REQ requesters.
// Results return in issue order through a tag FIFO. The request and response paths are purely combinational.
module arith_fptosi_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IN_WIDTH        = 32,
  parameter int OUT_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]       req_data,
  output logic                              cvt_a_valid,
  input  logic                              cvt_a_ready,
  output logic [IN_WIDTH-1:0]               cvt_a_data,
  input  logic                              cvt_result_valid,
  output logic                              cvt_result_ready,
  input  logic [OUT_WIDTH-1:0]              cvt_result_data,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [NUM_REQ*OUT_WIDTH-1:0]      resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_orphan
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    grant_reg, rr_ptr_reg;
  logic [IDX_W-1:0]    cand_idx, grant_idx, head_tag;
  logic                cand_found, grant_valid;
  logic                issue_fire, result_fire;
  logic                fifo_full, fifo_empty;
  logic [IDX_W-1:0]    tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                err_orphan_reg;
  logic [IN_WIDTH-1:0] req_data_arr [NUM_REQ];
  int                  scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign req_data_arr[gi] = req_data[gi*IN_WIDTH +: IN_WIDTH];
      assign req_ready[gi]    = issue_fire & (grant_idx == IDX_W'(gi));
      assign resp_valid[gi]   = ~rst & cvt_result_valid & ~fifo_empty & (head_tag == IDX_W'(gi));
      assign resp_data[gi*OUT_WIDTH +: OUT_WIDTH] = cvt_result_data;
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!cand_found && req_valid[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(scan_idx);
      end
    end
  end

  // Arbiter state register, plus the grant latch and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_OPEN;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_OPEN) grant_reg <= cand_idx;
      if (issue_fire)
        rr_ptr_reg <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OPEN:   if (cvt_a_valid && !cvt_a_ready) state_next = ST_LOCKED;
      ST_LOCKED: if (issue_fire) state_next = ST_OPEN;
      default:   state_next = ST_OPEN;
    endcase
  end

  always_comb begin
    grant_idx   = cand_idx;
    grant_valid = cand_found;
    if (state_reg == ST_LOCKED) begin
      grant_idx   = grant_reg;
      grant_valid = req_valid[grant_reg];
    end
  end

  assign fifo_full        = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty       = (count_reg == '0);
  // A pop in the same cycle never frees a slot for an issue while full.
  assign cvt_a_valid      = ~rst & grant_valid & ~fifo_full;
  assign cvt_a_data       = req_data_arr[grant_idx];
  assign issue_fire       = cvt_a_valid & cvt_a_ready;
  assign head_tag         = tag_mem[rd_ptr_reg];
  assign cvt_result_ready = ~rst & ~fifo_empty & resp_ready[head_tag];
  assign result_fire      = cvt_result_valid & cvt_result_ready;
  assign outstanding      = count_reg;
  assign err_orphan       = err_orphan_reg;

  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem[wr_ptr_reg] <= grant_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (issue_fire)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (result_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({issue_fire, result_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (cvt_result_valid && fifo_empty) err_orphan_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arith_fptosi_arbiter.sv
// Directed bench for arith_fptosi_arbiter; the bench itself plays the converter with hand-computed results.
module tb_arith_fptosi_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic         cvt_a_valid;
  logic         cvt_a_ready;
  logic [31:0]  cvt_a_data;
  logic         cvt_result_valid;
  logic         cvt_result_ready;
  logic [31:0]  cvt_result_data;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [127:0] resp_data;
  logic [2:0]   outstanding;
  logic         err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arith_fptosi_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .cvt_a_valid(cvt_a_valid), .cvt_a_ready(cvt_a_ready), .cvt_a_data(cvt_a_data),
    .cvt_result_valid(cvt_result_valid), .cvt_result_ready(cvt_result_ready),
    .cvt_result_data(cvt_result_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid        = '0;
    cvt_a_ready      = 1'b0;
    cvt_result_valid = 1'b0;
    cvt_result_data  = '0;
    resp_ready       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    req_valid        = 4'hF;
    req_data         = {32'h4, 32'h3, 32'h2, 32'h1};
    cvt_a_ready      = 1'b1;
    cvt_result_valid = 1'b1;
    cvt_result_data  = 32'h5;
    resp_ready       = 4'hF;
    #2;
    n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL rst_req_ready got=%h exp=0", req_ready); end
    n_cmp++; if (cvt_a_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cvt_a_valid got=%b exp=0", cvt_a_valid); end
    n_cmp++; if (resp_valid !== 4'h0) begin n_bad++; $display("FAIL rst_resp_valid got=%h exp=0", resp_valid); end
    n_cmp++; if (cvt_result_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cvt_result_ready got=%b exp=0", cvt_result_ready); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL rst_err_orphan got=%b exp=0", err_orphan); end
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL rst_release_err_orphan got=%b exp=0", err_orphan); end
    $display("reset: checked quiescent outputs");
  endtask

  task automatic test_single();
    do_reset();
    req_data[63:32] = 32'h3FC0_0000;
    req_valid   = 4'b0010;
    cvt_a_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_req_ready got=%b exp=0010", req_ready); end
    n_cmp++; if (cvt_a_data !== 32'h3FC0_0000) begin n_bad++; $display("FAIL single_a_data got=%h exp=3fc00000", cvt_a_data); end
    next_cycle();
    req_valid        = '0;
    cvt_result_valid = 1'b1;
    cvt_result_data  = 32'h0000_0001;
    resp_ready       = 4'b0010;
    #1;
    n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
    n_cmp++; if (resp_valid !== 4'b0010) begin n_bad++; $display("FAIL single_resp_valid got=%b exp=0010", resp_valid); end
    n_cmp++; if (resp_data[63:32] !== 32'h1) begin n_bad++; $display("FAIL single_resp_data got=%h exp=00000001", resp_data[63:32]); end
    n_cmp++; if (cvt_result_ready !== 1'b1) begin n_bad++; $display("FAIL single_result_ready got=%b exp=1", cvt_result_ready); end
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL single_drain got=%0d exp=0", outstanding); end
    $display("single: req1 1.5 -> 1");
  endtask

  task automatic test_fairness();
    logic [3:0] exp_grant [5];
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req_data    = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    req_valid   = 4'hF;
    cvt_a_ready = 1'b1;
    resp_ready  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cvt_result_valid = (k != 0);
      #1;
      n_cmp++; if (req_ready !== exp_grant[k]) begin n_bad++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, req_ready, exp_grant[k]); end
      n_cmp++; if (!$onehot(req_ready)) begin n_bad++; $display("FAIL fair_onehot[%0d] got=%b exp=one-hot", k, req_ready); end
      $display("fairness: cycle %0d req_ready=%b", k, req_ready);
      next_cycle();
    end
    req_valid        = '0;
    cvt_result_valid = 1'b1;
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL fair_drain got=%0d exp=0", outstanding); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL fair_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data    = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    req_valid   = 4'b0100;
    cvt_a_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_valid = 4'b0101;
      #1;
      n_cmp++; if (cvt_a_data !== 32'hAAAA_0002) begin n_bad++; $display("FAIL bp_data[%0d] got=%h exp=aaaa0002", k, cvt_a_data); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
      next_cycle();
    end
    cvt_a_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_handshake got=%b exp=0100", req_ready); end
    n_cmp++; if (cvt_a_data !== 32'hAAAA_0002) begin n_bad++; $display("FAIL bp_hs_data got=%h exp=aaaa0002", cvt_a_data); end
    $display("backpressure: issued req2 data=%h", cvt_a_data);
    next_cycle();
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready); end
    req_valid   = '0;
    cvt_a_ready = 1'b0;
    #1;
    next_cycle();
    cvt_result_valid = 1'b1;
    resp_ready       = 4'b0100;
    #1;
    n_cmp++; if (resp_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_resp_valid got=%b exp=0100", resp_valid); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    req_data    = {32'h0, 32'h0, 32'h0, 32'h4040_0000};
    req_valid   = 4'b0001;
    cvt_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (cvt_a_valid !== 1'b1) begin n_bad++; $display("FAIL full_issue[%0d] got=%b exp=1", k, cvt_a_valid); end
      next_cycle();
    end
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", outstanding); end
    n_cmp++; if (cvt_a_valid !== 1'b0) begin n_bad++; $display("FAIL full_block got=%b exp=0", cvt_a_valid); end
    cvt_result_valid = 1'b1;
    cvt_result_data  = 32'h3;
    resp_ready       = 4'b0001;
    #1;
    n_cmp++; if (cvt_a_valid !== 1'b0) begin n_bad++; $display("FAIL full_no_bypass got=%b exp=0", cvt_a_valid); end
    n_cmp++; if (cvt_result_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_ready got=%b exp=1", cvt_result_ready); end
    next_cycle();
    cvt_result_valid = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("FAIL full_after_pop got=%0d exp=3", outstanding); end
    n_cmp++; if (cvt_a_valid !== 1'b1) begin n_bad++; $display("FAIL full_reissue got=%b exp=1", cvt_a_valid); end
    $display("full: pop then reissue");
    next_cycle();
    req_valid        = '0;
    cvt_result_valid = 1'b1;
    for (int k = 0; k < 4; k++) next_cycle();
    cvt_result_valid = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL full_drain got=%0d exp=0", outstanding); end
    idle_inputs();
  endtask

  task automatic test_ordering();
    do_reset();
    req_data    = {32'hC020_0000, 32'h0, 32'h0, 32'h3F80_0000};
    req_valid   = 4'b1000;
    cvt_a_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL ord_issue3 got=%b exp=1000", req_ready); end
    next_cycle();
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL ord_issue0 got=%b exp=0001", req_ready); end
    next_cycle();
    req_valid        = '0;
    cvt_result_valid = 1'b1;
    cvt_result_data  = 32'hFFFF_FFFE;
    resp_ready       = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (resp_valid !== 4'b1000) begin n_bad++; $display("FAIL ord_hold_valid[%0d] got=%b exp=1000", k, resp_valid); end
      n_cmp++; if (cvt_result_ready !== 1'b0) begin n_bad++; $display("FAIL ord_hold_ready[%0d] got=%b exp=0", k, cvt_result_ready); end
      next_cycle();
    end
    resp_ready = 4'b1001;
    #1;
    n_cmp++; if (resp_data[127:96] !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL ord_data3 got=%h exp=fffffffe", resp_data[127:96]); end
    n_cmp++; if (cvt_result_ready !== 1'b1) begin n_bad++; $display("FAIL ord_accept3 got=%b exp=1", cvt_result_ready); end
    $display("ordering: resp to 3 data=%h", resp_data[127:96]);
    next_cycle();
    cvt_result_data = 32'h0000_0001;
    #1;
    n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL ord_valid0 got=%b exp=0001", resp_valid); end
    n_cmp++; if (resp_data[31:0] !== 32'h1) begin n_bad++; $display("FAIL ord_data0 got=%h exp=00000001", resp_data[31:0]); end
    $display("ordering: resp to 0 data=%h", resp_data[31:0]);
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL ord_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_orphan();
    do_reset();
    req_valid   = 4'b0011;
    cvt_a_ready = 1'b1;
    next_cycle();
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd2) begin n_bad++; $display("FAIL orph_inflight got=%0d exp=2", outstanding); end
    rst = 1'b1;
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL orph_async_clear got=%0d exp=0", outstanding); end
    next_cycle();
    rst = 1'b0;
    cvt_result_valid = 1'b1;
    cvt_result_data  = 32'h7;
    resp_ready       = 4'hF;
    #1;
    n_cmp++; if (cvt_result_ready !== 1'b0) begin n_bad++; $display("FAIL orph_ready got=%b exp=0", cvt_result_ready); end
    n_cmp++; if (resp_valid !== 4'h0) begin n_bad++; $display("FAIL orph_resp_valid got=%b exp=0", resp_valid); end
    next_cycle();
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orph_flag got=%b exp=1", err_orphan); end
    idle_inputs();
    next_cycle();
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orph_sticky got=%b exp=1", err_orphan); end
    $display("orphan: late result flagged err_orphan=%b", err_orphan);
  endtask

  initial begin
    req_data = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_full();
    test_ordering();
    test_orphan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_fptosi_arbiter.md
ARITH_FPTOSI_ARBITER -- requirements
Module: arith_fptosi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter IN_WIDTH, default 32, float operand width (32 or 64).
REQ-003 SHALL have parameter OUT_WIDTH, default 32, integer result width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, capacity of the in-flight tag FIFO (power of two, 2..16).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester operand valid.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester operand accept.
REQ-009 SHALL have port req_data, input, NUM_REQ*IN_WIDTH, operands; requester i in slice [i*IN_WIDTH +: IN_WIDTH].
REQ-010 SHALL have ports cvt_a_valid (output, 1), cvt_a_ready (input, 1), cvt_a_data (output, IN_WIDTH), the operand side of the shared converter.
REQ-011 SHALL have ports cvt_result_valid (input, 1), cvt_result_ready (output, 1), cvt_result_data (input, OUT_WIDTH), the result side of the shared converter.
REQ-012 SHALL have port resp_valid, output, NUM_REQ, per-requester result valid.
REQ-013 SHALL have port resp_ready, input, NUM_REQ, per-requester result accept.
REQ-014 SHALL have port resp_data, output, NUM_REQ*OUT_WIDTH, cvt_result_data broadcast to every slice.
REQ-015 SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING)+1, in-flight operation count.
REQ-016 SHALL have port err_orphan, output, 1, sticky flag for a converter result with no outstanding tag.

Function
REQ-017 SHALL arbitrate round-robin: the candidate is the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-018 SHALL use two arbiter states: OPEN (grant computed combinationally each cycle) and LOCKED (grant held).
REQ-019 SHALL move OPEN -> LOCKED when cvt_a_valid=1 and cvt_a_ready=0, and LOCKED -> OPEN on the issue handshake; while LOCKED, cvt_a_data and the granted index SHALL stay constant.
REQ-020 SHALL drive cvt_a_valid = (a candidate exists) AND (tag FIFO not full), and cvt_a_data = req_data slice of the granted requester.
REQ-021 SHALL assert req_ready[g] = cvt_a_ready AND cvt_a_valid only for the granted index g; all other req_ready bits SHALL be 0.
REQ-022 On each issue handshake, SHALL push g into the tag FIFO and set rr_ptr to (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-023 SHALL block issue whenever the FIFO is full, even if a pop occurs in the same cycle (no full-bypass).
REQ-024 SHALL set resp_valid[i] = cvt_result_valid AND FIFO not empty AND head tag == i, and cvt_result_ready = FIFO not empty AND resp_ready[head tag].
REQ-025 SHALL pop the FIFO on the result handshake, so results return in issue order.
REQ-026 A push and a pop in the same cycle SHALL leave outstanding unchanged; the FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-027 SHALL set err_orphan when cvt_result_valid=1 while the FIFO is empty; the result SHALL NOT be accepted (cvt_result_ready=0).
REQ-028 SHALL add zero cycles of latency beyond the converter: issue and return paths are combinational, and the only state is the arbiter state, rr_ptr and the FIFO.

Reset
REQ-029 While rst=1, SHALL asynchronously clear: state to OPEN, rr_ptr to 0, FIFO empty, outstanding to 0, err_orphan to 0.
REQ-030 While rst=1, all req_ready, resp_valid, cvt_a_valid and cvt_result_ready SHALL be 0.
REQ-031 After reset mid-operation, in-flight tags SHALL be discarded; any late converter result SHALL set err_orphan.

Verification
REQ-032 Single request: req 1 sends 0x3FC00000 (1.5), converter delay 0 -> resp_valid[1]=1 with resp_data slice 0x00000001; outstanding returns to 0.
REQ-033 Fairness: all four requesters held valid, cvt_a_ready=1 -> grant order 0,1,2,3,0; req_ready is one-hot each cycle.
REQ-034 Backpressure: cvt_a_ready=0 for 3 cycles with req 2 granted, then req 0 raises valid -> grant stays 2 and cvt_a_data stays stable until the handshake.
REQ-035 Full: MAX_OUTSTANDING=4, 4 issues with cvt_result_valid=0 -> outstanding=4 and cvt_a_valid=0; one pop -> next issue the following cycle.
REQ-036 Ordering/negative: req 3 issues 0xC0200000 (-2.5) then req 0 issues 0x3F800000 (1.0), resp_ready[3]=0 for 2 cycles -> resp 0xFFFFFFFE to 3 first, then 0x00000001 to 0.
REQ-037 Orphan/reset: pulse rst with 2 outstanding, then drive cvt_result_valid=1 -> err_orphan=1 and cvt_result_ready=0.
